// File: rtl/sim_lane_responder.sv
// Multi-lane request/response responder for simulation fabrics.
// Each lane queues accepted requests in order and answers each one a fixed
// LATENCY after acceptance, echoing the request's is_store and size fields.
// Address and store data are accepted but not kept.
module sim_lane_responder #(
  parameter int NUM_LANES     = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int LOGSIZE_WIDTH = 8,
  parameter int DEPTH         = 4,
  parameter int LATENCY       = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  output logic [NUM_LANES-1:0]               a_ready,
  input  logic [NUM_LANES-1:0]               a_valid,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_address,
  input  logic [NUM_LANES-1:0]               a_is_store,
  input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] a_size,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_data,
  input  logic [NUM_LANES-1:0]               d_ready,
  output logic [NUM_LANES-1:0]               d_valid,
  output logic [NUM_LANES-1:0]               d_is_store,
  output logic [LOGSIZE_WIDTH*NUM_LANES-1:0] d_size,
  output logic                               inflight
);

  localparam int DLY_W = $clog2(LATENCY + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [NUM_LANES-1:0] lane_busy;

  // Address and store data are part of the handshake but carry no state.
  logic unused_payload;
  assign unused_payload = ^{a_address, a_data};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic                     st_q  [DEPTH];
    logic [LOGSIZE_WIDTH-1:0] sz_q  [DEPTH];
    logic [DLY_W-1:0]         dly_q [DEPTH];
    logic [DLY_W-1:0]         dly_d [DEPTH];
    logic [PTR_W-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     push, pop;

    // Acceptance depends on registered occupancy only, so a full lane never
    // takes a new request even on the edge its head is popped.
    assign push = a_valid[g] && (cnt_q < CNT_MAX);
    assign pop  = d_valid[g] && d_ready[g];

    // Next-state for pointers, occupancy and per-entry latency counters.
    always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + PTR_W'(1);
      if (pop)  rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      // Free slots also count down; their value is overwritten on enqueue,
      // so this is invisible and saves an occupancy mask.
      for (int i = 0; i < DEPTH; i++) begin
        dly_d[i] = (dly_q[i] != '0) ? dly_q[i] - DLY_W'(1) : '0;
        if (push && (wr_q == PTR_W'(i))) dly_d[i] = DLY_INIT;
      end
    end

    // Control state: flushed by reset.
    always_ff @(posedge clock) begin
      if (reset) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        for (int i = 0; i < DEPTH; i++) dly_q[i] <= '0;
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
        for (int i = 0; i < DEPTH; i++) dly_q[i] <= dly_d[i];
      end
    end

    // Echoed request fields: written on accept, never reset.
    always_ff @(posedge clock) begin
      if (push) begin
        st_q[wr_q] <= a_is_store[g];
        sz_q[wr_q] <= a_size[g*LOGSIZE_WIDTH +: LOGSIZE_WIDTH];
      end
    end

    assign a_ready[g]   = (cnt_q < CNT_MAX);
    assign lane_busy[g] = (cnt_q != '0);
    assign d_valid[g]   = lane_busy[g] && (dly_q[rd_q] == '0);
    // Fields are forced to zero when idle so stale entries never leak out.
    assign d_is_store[g] = d_valid[g] & st_q[rd_q];
    assign d_size[g*LOGSIZE_WIDTH +: LOGSIZE_WIDTH] =
      d_valid[g] ? sz_q[rd_q] : '0;
  end

  assign inflight = |lane_busy;

endmodule

// File: tb/tb_sim_lane_responder.sv
// Bench for sim_lane_responder: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the lanes.
module tb_sim_lane_responder;

  localparam int NL    = 4;
  localparam int DW    = 64;
  localparam int LW    = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NL-1:0]     a_ready, a_valid, a_is_store, d_ready;
  logic [NL-1:0]     d_valid, d_is_store;
  logic [DW*NL-1:0]  a_address, a_data;
  logic [LW*NL-1:0]  a_size, d_size;
  logic              inflight;

  always #5 clock = ~clock;

  sim_lane_responder #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(LW),
    .DEPTH(DEPTH), .LATENCY(LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .a_ready(a_ready), .a_valid(a_valid), .a_address(a_address),
    .a_is_store(a_is_store), .a_size(a_size), .a_data(a_data),
    .d_ready(d_ready), .d_valid(d_valid), .d_is_store(d_is_store),
    .d_size(d_size), .inflight(inflight)
  );

  int checks = 0;
  int errors = 0;
  int pops3  = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: each lane is a queue of requests tagged with the edge count after
  // which they become visible as responses.
  typedef struct packed {
    logic          st;
    logic [LW-1:0] sz;
    int unsigned   elig;
  } ent_t;

  ent_t        mq[NL][$];
  int unsigned ecnt = 0;

  function automatic bit head_ready(input int g);
    if (mq[g].size() == 0) return 1'b0;
    return ecnt >= mq[g][0].elig;
  endfunction

  task automatic model_edge();
    bit   acc[NL];
    bit   pop[NL];
    ent_t e;
    if (reset) begin
      for (int g = 0; g < NL; g++) mq[g].delete();
      ecnt++;
      return;
    end
    for (int g = 0; g < NL; g++) begin
      acc[g] = a_valid[g] && (mq[g].size() < DEPTH);
      pop[g] = head_ready(g) && d_ready[g];
    end
    ecnt++;
    for (int g = 0; g < NL; g++) begin
      if (pop[g]) void'(mq[g].pop_front());
      if (acc[g]) begin
        e.st   = a_is_store[g];
        e.sz   = a_size[g*LW +: LW];
        e.elig = ecnt + LAT - 1;
        mq[g].push_back(e);
      end
    end
  endtask

  task automatic compare_all();
    bit any;
    any = 1'b0;
    for (int g = 0; g < NL; g++) begin
      check_val($sformatf("a_ready[%0d] t=%0d", g, ecnt), 64'(a_ready[g]),
                64'(mq[g].size() < DEPTH));
      check_val($sformatf("d_valid[%0d] t=%0d", g, ecnt), 64'(d_valid[g]),
                64'(head_ready(g)));
      if (head_ready(g)) begin
        check_val($sformatf("d_is_store[%0d] t=%0d", g, ecnt),
                  64'(d_is_store[g]), 64'(mq[g][0].st));
        check_val($sformatf("d_size[%0d] t=%0d", g, ecnt),
                  64'(d_size[g*LW +: LW]), 64'(mq[g][0].sz));
      end
      if (mq[g].size() != 0) any = 1'b1;
    end
    check_val($sformatf("inflight t=%0d", ecnt), 64'(inflight), 64'(any));
  endtask

  // Inputs are set at the falling edge before calling; outputs are compared
  // at the following falling edge.
  task automatic tick();
    if (d_valid[3] && d_ready[3] && !reset) pops3++;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  task automatic idle();
    reset      = 1'b0;
    a_valid    = '0;
    a_is_store = '0;
    a_size     = '0;
    a_address  = '0;
    a_data     = '0;
    d_ready    = '0;
  endtask

  task automatic set_req(input int g, input logic st, input logic [LW-1:0] sz);
    a_valid[g]          = 1'b1;
    a_is_store[g]       = st;
    a_size[g*LW +: LW]  = sz;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clock);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Single load on lane 0 with LATENCY 2.
    d_ready = '1;
    set_req(0, 1'b0, 8'd2);
    tick();
    check_val("lat_early_valid0", 64'(d_valid[0]), 64'd0);
    a_valid = '0;
    tick();
    check_val("lat_valid0", 64'(d_valid[0]), 64'd1);
    check_val("lat_size0", 64'(d_size[7:0]), 64'd2);
    check_val("lat_store0", 64'(d_is_store[0]), 64'd0);
    tick();
    check_val("lat_inflight_low", 64'(inflight), 64'd0);

    // Lane 1 fills to DEPTH, then one pop re-opens it.
    idle();
    set_req(1, 1'b1, 8'd5);
    repeat (5) tick();
    check_val("full_ready1", 64'(a_ready[1]), 64'd0);
    d_ready[1] = 1'b1;
    tick();
    check_val("reopen_ready1", 64'(a_ready[1]), 64'd1);
    d_ready[1] = 1'b0;
    tick();
    check_val("refull_ready1", 64'(a_ready[1]), 64'd0);
    a_valid = '0;
    d_ready = '1;
    repeat (6) tick();

    // Lane 2 store then load, held back, then drained in order.
    idle();
    set_req(2, 1'b1, 8'd3);
    tick();
    set_req(2, 1'b0, 8'd1);
    tick();
    a_valid = '0;
    repeat (4) tick();
    d_ready = '1;
    check_val("order_first_store", 64'(d_is_store[2]), 64'd1);
    check_val("order_first_size", 64'(d_size[23:16]), 64'd3);
    tick();
    check_val("order_second_valid", 64'(d_valid[2]), 64'd1);
    check_val("order_second_size", 64'(d_size[23:16]), 64'd1);
    tick();
    tick();

    // All lanes accept together.
    idle();
    for (int g = 0; g < NL; g++) set_req(g, g[0], 8'(g + 8));
    tick();
    a_valid = '0;
    tick();
    check_val("all_lanes_valid", 64'(d_valid), 64'hf);
    d_ready = '1;
    tick();
    check_val("all_lanes_drained", 64'(inflight), 64'd0);

    // Reset flushes pending entries on lane 0.
    idle();
    set_req(0, 1'b1, 8'd7);
    repeat (3) tick();
    a_valid = '0;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    check_val("rst_d_valid", 64'(d_valid), 64'd0);
    check_val("rst_a_ready", 64'(a_ready), 64'hf);
    check_val("rst_inflight", 64'(inflight), 64'd0);
    check_val("rst_d_size", 64'(d_size), 64'd0);
    check_val("rst_d_is_store", 64'(d_is_store), 64'd0);
    d_ready = '1;
    repeat (4) tick();
    check_val("rst_no_stale", 64'(d_valid), 64'd0);

    // Lane 3 steady state: two entries, enqueue and pop each cycle.
    idle();
    set_req(3, 1'b0, 8'd100);
    tick();
    set_req(3, 1'b1, 8'd101);
    tick();
    a_valid = '0;
    tick();
    pops3 = 0;
    for (int i = 0; i < 20; i++) begin
      set_req(3, 1'(i), 8'(i + 1));
      d_ready[3] = 1'b1;
      tick();
      check_val($sformatf("steady_valid3 i=%0d", i), 64'(d_valid[3]), 64'd1);
    end
    check_val("steady_pops3", 64'(pops3), 64'd20);
    check_val("steady_ready3", 64'(a_ready[3]), 64'd1);
    a_valid = '0;
    d_ready = '1;
    repeat (4) tick();

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int g = 0; g < NL; g++) begin
        a_valid[g]         = ($urandom_range(0, 2) != 0);
        a_is_store[g]      = 1'($urandom);
        a_size[g*LW +: LW] = 8'($urandom);
        d_ready[g]         = ($urandom_range(0, 3) != 0);
      end
      a_address = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
      a_data    = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
      tick();
    end

    idle();
    d_ready = '1;
    repeat (8) tick();
    check_val("final_inflight", 64'(inflight), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Backstop so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
